slice_scheduler: RTL

- Sequences the 769-bit LED-driver shift engine for the rotating volumetric display.
- After reset it issues the control-latch writes. It then locks to the encoder home pulse, preloads grayscale data for the next angular slice, and fires LAT on each encoder slice tick.
- Sits between the encoder pins and the shift engine. It owns the engine's start/select/slice inputs and the LAT strobe.

---
 rtl/slice_sched_pkg.sv | 30 +++
 rtl/slice_scheduler_enc_edge_sync.sv | 42 ++++
 rtl/slice_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slice_sched_pkg
// Description : Shared types and constants for the volumetric-display slice
//               scheduler: FSM state encoding, slice-index width helper and
//               default timing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package slice_sched_pkg;

    typedef enum logic [2:0] {
        CFG_SHIFT = 3'd0,   // shifting a control-latch word
        CFG_LAT   = 3'd1,   // strobing LAT for a control write
        WAIT_HOME = 3'd2,   // configured, waiting for first home pulse
        PRELOAD   = 3'd3,   // shifting grayscale for the next slice
        ARMED     = 3'd4,   // preload complete, waiting for slice tick
        LATCH     = 3'd5    // strobing LAT to display the preloaded slice
    } sched_state_t;

    localparam int c_SLICES_PER_REV = 360;
    localparam int c_CTRL_WRITES    = 2;
    localparam int c_LAT_CYCLES     = 2;

    // Width of a slice index; never narrower than one bit.
    function automatic int slice_width(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_scheduler_enc_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : enc_edge_sync
// Description : Two-flop synchroniser for an asynchronous encoder pin followed
//               by a registered rising-edge detector. The pulse appears
//               3 clocks after the pin edge and lasts one clock.
// Ports       : TESTCLK  - clock
//               nReset   - synchronous active-low reset
//               pin      - raw asynchronous pin
//               pulse    - 1-cycle pulse on a synchronised rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module enc_edge_sync (
    input  logic TESTCLK,
    input  logic nReset,
    input  logic pin,
    output logic pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= pin;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/slice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : slice_scheduler
// Description : Sequences the LED-driver shift engine: control-latch writes
//               after reset / on request, lock to encoder home, grayscale
//               preload of the next slice and LAT on every slice tick.
// Ports       : TESTCLK, nReset      - clock, synchronous active-low reset
//               enc_home, enc_tick   - raw encoder pins (asynchronous)
//               cfg_update           - request a control-latch rewrite
//               sh_start/sel/slice   - shift-engine command
//               sh_done              - shift-engine completion pulse
//               lat, disp_slice      - driver latch strobe, displayed slice
//               locked, overrun, rev_err, overrun_cnt - status
// Revision    : 1.0 - initial release
// ============================================================================
module slice_scheduler
    import slice_sched_pkg::*;
#(
    parameter int SLICES_PER_REV = c_SLICES_PER_REV,
    parameter int SLICE_W        = slice_width(SLICES_PER_REV),
    parameter int CTRL_WRITES    = c_CTRL_WRITES,
    parameter int LAT_CYCLES     = c_LAT_CYCLES
) (
    input  logic               TESTCLK,
    input  logic               nReset,
    input  logic               enc_home,
    input  logic               enc_tick,
    input  logic               cfg_update,
    output logic               sh_start,
    output logic               sh_sel,
    output logic [SLICE_W-1:0] sh_slice,
    input  logic               sh_done,
    output logic               lat,
    output logic [SLICE_W-1:0] disp_slice,
    output logic               locked,
    output logic               overrun,
    output logic               rev_err,
    output logic [7:0]         overrun_cnt
);

    localparam int c_LAT_W = (LAT_CYCLES > 1) ? $clog2(LAT_CYCLES) : 1;
    localparam int c_WR_W  = $clog2(CTRL_WRITES + 1);
    localparam int c_CNT_W = $clog2(SLICES_PER_REV + 2);

    logic w_home;
    logic w_tick;

    enc_edge_sync u_home_sync (
        .TESTCLK (TESTCLK),
        .nReset  (nReset),
        .pin     (enc_home),
        .pulse   (w_home)
    );

    enc_edge_sync u_tick_sync (
        .TESTCLK (TESTCLK),
        .nReset  (nReset),
        .pin     (enc_tick),
        .pulse   (w_tick)
    );

    sched_state_t       r_state,       w_state_nxt;
    logic [c_LAT_W-1:0] r_lat_cnt,     w_lat_cnt_nxt;
    logic [c_WR_W-1:0]  r_wr_cnt,      w_wr_cnt_nxt;
    logic [c_CNT_W-1:0] r_tick_cnt,    w_tick_cnt_nxt;
    logic [SLICE_W-1:0] r_target,      w_target_nxt;
    logic [SLICE_W-1:0] r_sh_slice,    w_sh_slice_nxt;
    logic [SLICE_W-1:0] r_disp_slice,  w_disp_slice_nxt;
    logic [7:0]         r_overrun_cnt, w_overrun_cnt_nxt;
    logic r_busy,     w_busy_nxt;      // shift in flight, waiting for sh_done
    logic r_cfg_done, w_cfg_done_nxt;  // first configuration has completed
    logic r_cfg_pend, w_cfg_pend_nxt;
    logic r_home_pend, w_home_pend_nxt; // target must restart at 0 on next preload
    logic r_sh_start, w_sh_start_nxt;
    logic r_sh_sel,   w_sh_sel_nxt;
    logic r_lat,      w_lat_nxt;
    logic r_locked,   w_locked_nxt;
    logic r_overrun,  w_overrun_nxt;
    logic r_rev_err,  w_rev_err_nxt;

    logic              w_home_lk;
    logic              w_tick_eff;
    logic              w_tick_accept;
    logic              w_lat_last;
    logic [c_WR_W-1:0] w_wr_inc;

    // Home wins over a coincident tick; the tick is simply dropped.
    assign w_home_lk     = w_home & r_locked;
    assign w_tick_eff    = w_tick & ~w_home;
    assign w_tick_accept = w_tick_eff && (r_state == ARMED) && !r_cfg_pend;
    assign w_lat_last    = (r_lat_cnt == c_LAT_W'(LAT_CYCLES - 1));
    assign w_wr_inc      = r_wr_cnt + c_WR_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_lat_cnt_nxt     = r_lat_cnt;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_tick_cnt_nxt    = r_tick_cnt;
        w_target_nxt      = r_target;
        w_sh_slice_nxt    = r_sh_slice;
        w_disp_slice_nxt  = r_disp_slice;
        w_overrun_cnt_nxt = r_overrun_cnt;
        w_busy_nxt        = r_busy;
        w_cfg_done_nxt    = r_cfg_done;
        w_cfg_pend_nxt    = r_cfg_pend | cfg_update;
        w_home_pend_nxt   = r_home_pend;
        w_sh_start_nxt    = 1'b0;
        w_sh_sel_nxt      = r_sh_sel;
        w_lat_nxt         = r_lat;
        w_locked_nxt      = r_locked;
        w_overrun_nxt     = r_overrun;
        w_rev_err_nxt     = r_rev_err;

        if (w_home_lk) begin
            if (r_tick_cnt != c_CNT_W'(SLICES_PER_REV)) begin
                w_rev_err_nxt = 1'b1;
            end
            w_tick_cnt_nxt  = '0;
            w_home_pend_nxt = 1'b1;
        end

        // Any post-lock tick that cannot be latched right now is dropped.
        if (w_tick_eff && r_locked && !w_tick_accept) begin
            w_overrun_nxt = 1'b1;
            if (r_overrun_cnt != 8'hFF) begin
                w_overrun_cnt_nxt = r_overrun_cnt + 8'd1;
            end
        end

        case (r_state)
            CFG_SHIFT: begin
                if (!r_busy) begin
                    w_sh_start_nxt = 1'b1;
                    w_sh_sel_nxt   = 1'b1;
                    w_busy_nxt     = 1'b1;
                end else if (sh_done) begin
                    w_busy_nxt    = 1'b0;
                    w_lat_nxt     = 1'b1;
                    w_lat_cnt_nxt = '0;
                    w_state_nxt   = CFG_LAT;
                end
            end
            CFG_LAT: begin
                if (w_lat_last) begin
                    w_lat_nxt     = 1'b0;
                    w_lat_cnt_nxt = '0;
                    if (w_wr_inc < c_WR_W'(CTRL_WRITES)) begin
                        w_wr_cnt_nxt = w_wr_inc;
                        w_state_nxt  = CFG_SHIFT;
                    end else begin
                        w_wr_cnt_nxt = '0;
                        if (!r_cfg_done) begin
                            w_cfg_done_nxt = 1'b1;
                            w_state_nxt    = WAIT_HOME;
                        end else begin
                            w_state_nxt = PRELOAD;
                        end
                    end
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + c_LAT_W'(1);
                end
            end
            WAIT_HOME: begin
                if (w_home) begin
                    w_target_nxt    = '0;
                    w_tick_cnt_nxt  = '0;
                    w_locked_nxt    = 1'b1;
                    w_home_pend_nxt = 1'b0;
                    w_state_nxt     = PRELOAD;
                end
            end
            PRELOAD: begin
                if (!r_busy) begin
                    w_sh_start_nxt = 1'b1;
                    w_sh_sel_nxt   = 1'b0;
                    w_busy_nxt     = 1'b1;
                    if (r_home_pend || w_home_lk) begin
                        w_sh_slice_nxt  = '0;
                        w_target_nxt    = '0;
                        w_home_pend_nxt = 1'b0;
                    end else begin
                        w_sh_slice_nxt = r_target;
                    end
                end else if (sh_done) begin
                    w_busy_nxt = 1'b0;
                    if (r_cfg_pend) begin
                        w_cfg_pend_nxt = 1'b0;
                        w_state_nxt    = CFG_SHIFT;
                    end else if (!(r_home_pend || w_home_lk)) begin
                        w_state_nxt = ARMED;
                    end
                    // A home during the shift stays in PRELOAD to reissue slice 0.
                end
            end
            ARMED: begin
                if (w_home_lk) begin
                    w_state_nxt = PRELOAD;
                end else if (r_cfg_pend) begin
                    w_cfg_pend_nxt = 1'b0;
                    w_state_nxt    = CFG_SHIFT;
                end else if (w_tick_accept) begin
                    w_lat_nxt        = 1'b1;
                    w_lat_cnt_nxt    = '0;
                    w_disp_slice_nxt = r_target;
                    w_target_nxt     = (r_target == SLICE_W'(SLICES_PER_REV - 1)) ?
                                       '0 : r_target + SLICE_W'(1);
                    if (r_tick_cnt != c_CNT_W'(SLICES_PER_REV + 1)) begin
                        w_tick_cnt_nxt = r_tick_cnt + c_CNT_W'(1);
                    end
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                if (w_lat_last) begin
                    w_lat_nxt     = 1'b0;
                    w_lat_cnt_nxt = '0;
                    w_state_nxt   = PRELOAD;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + c_LAT_W'(1);
                end
            end
            default: begin
                w_state_nxt = CFG_SHIFT;
            end
        endcase
    end

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            r_state       <= CFG_SHIFT;
            r_lat_cnt     <= '0;
            r_wr_cnt      <= '0;
            r_tick_cnt    <= '0;
            r_target      <= '0;
            r_sh_slice    <= '0;
            r_disp_slice  <= '0;
            r_overrun_cnt <= '0;
            r_busy        <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_cfg_pend    <= 1'b0;
            r_home_pend   <= 1'b0;
            r_sh_start    <= 1'b0;
            r_sh_sel      <= 1'b0;
            r_lat         <= 1'b0;
            r_locked      <= 1'b0;
            r_overrun     <= 1'b0;
            r_rev_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_lat_cnt     <= w_lat_cnt_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_tick_cnt    <= w_tick_cnt_nxt;
            r_target      <= w_target_nxt;
            r_sh_slice    <= w_sh_slice_nxt;
            r_disp_slice  <= w_disp_slice_nxt;
            r_overrun_cnt <= w_overrun_cnt_nxt;
            r_busy        <= w_busy_nxt;
            r_cfg_done    <= w_cfg_done_nxt;
            r_cfg_pend    <= w_cfg_pend_nxt;
            r_home_pend   <= w_home_pend_nxt;
            r_sh_start    <= w_sh_start_nxt;
            r_sh_sel      <= w_sh_sel_nxt;
            r_lat         <= w_lat_nxt;
            r_locked      <= w_locked_nxt;
            r_overrun     <= w_overrun_nxt;
            r_rev_err     <= w_rev_err_nxt;
        end
    end

    assign sh_start    = r_sh_start;
    assign sh_sel      = r_sh_sel;
    assign sh_slice    = r_sh_slice;
    assign lat         = r_lat;
    assign disp_slice  = r_disp_slice;
    assign locked      = r_locked;
    assign overrun     = r_overrun;
    assign rev_err     = r_rev_err;
    assign overrun_cnt = r_overrun_cnt;

endmodule
`default_nettype wire
